// File: rtl/hpc2_and_scheduler.sv
// hpc2_and_scheduler: shares one first-order HPC2 masked AND gadget (1-cycle latency)
//   between two requesters with round-robin arbitration, LFSR fresh randomness and
//   an ID-tagged result FIFO.
// Latency: grant in cycle t, gadget result captured at end of t+1, earliest out_valid in t+2.
// Backpressure: grant only while fifo_count + inflight < FIFO_DEPTH; the gadget itself never stalls.
// Ports:
//   clock_0, reset_0 (async, active-low)
//   req{0,1}_valid/_ready/_ops  : ops = {b_s1,b_s0,a_s1,a_s0}; ready = granted this cycle
//   g_i0_s*, g_i1_s*, g_rand    : gadget operand shares (a=i0, b=i1) and fresh random bit
//   g_o0_s0, g_o0_s1            : gadget result shares (valid one cycle after issue)
//   out_valid/out_ready/out_s/out_id : FIFO head, out_s = {s1,s0}
//   seed_load, seed_value       : reseed the LFSR (zero maps to SEED)
module hpc2_and_scheduler #(
   parameter int                LFSR_W     = 16,
   parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clock_0,
   input  logic              reset_0,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [3:0]        req0_ops,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [3:0]        req1_ops,
   output logic              g_i0_s0,
   output logic              g_i0_s1,
   output logic              g_i1_s0,
   output logic              g_i1_s1,
   output logic              g_rand,
   input  logic              g_o0_s0,
   input  logic              g_o0_s1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_s,
   output logic              out_id,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_value
);

   localparam int                CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

   logic [CNT_W-1:0]  count_q, count_d;
   logic              inflight_q, inflight_d;
   logic              inflight_id_q, inflight_id_d;
   logic              last_grant_q, last_grant_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [1:0]        mem_s_q  [FIFO_DEPTH];
   logic              mem_id_q [FIFO_DEPTH];

   logic [CNT_W:0]    credit_used;
   logic              can_issue;
   logic              grant_vld;
   logic              grant_id;
   logic [3:0]        grant_ops;
   logic              wr_en;
   logic              pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Arbitration and gadget drive. Credit uses registered state only, so a pop
   // in the current cycle frees a slot one cycle later. Grants are suppressed
   // while reset is held so no share leaves the block during reset.
   always_comb begin
      credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
      can_issue   = credit_used < DEPTH_C;
      grant_vld   = reset_0 && can_issue && (req0_valid || req1_valid);
      // Both valid: alternate away from the last winner; otherwise the lone requester.
      grant_id    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
      // Idle cycles drive all-zero shares rather than holding stale secrets.
      grant_ops   = 4'b0000;
      if (grant_vld) begin
         grant_ops = grant_id ? req1_ops : req0_ops;
      end
   end

   assign req0_ready = grant_vld & ~grant_id;
   assign req1_ready = grant_vld &  grant_id;
   assign g_i0_s0    = grant_ops[0];
   assign g_i0_s1    = grant_ops[1];
   assign g_i1_s0    = grant_ops[2];
   assign g_i1_s1    = grant_ops[3];
   assign g_rand     = lfsr_q[0];

   // Registered FIFO head; out_s/out_id come straight from storage flops.
   assign out_valid = (count_q != '0);
   assign out_s     = mem_s_q[rd_ptr_q];
   assign out_id    = mem_id_q[rd_ptr_q];

   always_comb begin
      inflight_d    = grant_vld;
      inflight_id_d = grant_vld ? grant_id : inflight_id_q;
      last_grant_d  = grant_vld ? grant_id : last_grant_q;

      // x^16+x^14+x^13+x^11+1, Fibonacci form shifting toward bit 0.
      lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LFSR_W-1:1]};
      lfsr_d    = lfsr_q;
      if (seed_load) begin
         // Reseeding wins over stepping; the all-zero lock-up state is never loaded.
         lfsr_d = (seed_value == '0) ? SEED : seed_value;
      end else if (grant_vld) begin
         lfsr_d = lfsr_step;
      end

      // The gadget result is valid exactly one cycle after issue.
      wr_en    = inflight_q;
      pop      = out_valid && out_ready;
      wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock_0 or negedge reset_0) begin
      if (!reset_0) begin
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_id_q <= 1'b0;
         last_grant_q  <= 1'b1;
         lfsr_q        <= SEED;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_id_q <= inflight_id_d;
         last_grant_q  <= last_grant_d;
         lfsr_q        <= lfsr_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock_0 or negedge reset_0) begin
      if (!reset_0) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_s_q[i]  <= 2'b00;
            mem_id_q[i] <= 1'b0;
         end
      end else if (wr_en) begin
         mem_s_q[wr_ptr_q]  <= {g_o0_s1, g_o0_s0};
         mem_id_q[wr_ptr_q] <= inflight_id_q;
      end
   end

   // Credit accounting guarantees a free slot for every in-flight result.
   a_no_overflow: assert property (@(posedge clock_0) disable iff (!reset_0)
      wr_en |-> ({1'b0, count_q} < DEPTH_C));

endmodule

// File: tb/tb_hpc2_and_scheduler.sv
module tb_hpc2_and_scheduler;
   logic        clock_0 = 1'b0;
   logic        reset_0;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_ops, req1_ops;
   logic        g_i0_s0, g_i0_s1, g_i1_s0, g_i1_s1, g_rand;
   logic        g_o0_s0 = 1'b0;
   logic        g_o0_s1 = 1'b0;
   logic        out_valid, out_ready, out_id;
   logic [1:0]  out_s;
   logic        seed_load;
   logic [15:0] seed_value;
   logic [3:0]  gsh;
   logic [1:0]  sb [$];
   logic [1:0]  exp_r;
   int          nvec = 0;
   int          nerr = 0;

   always #5 clock_0 = ~clock_0;

   hpc2_and_scheduler dut (
      .clock_0(clock_0), .reset_0(reset_0),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ops(req0_ops),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ops(req1_ops),
      .g_i0_s0(g_i0_s0), .g_i0_s1(g_i0_s1), .g_i1_s0(g_i1_s0), .g_i1_s1(g_i1_s1),
      .g_rand(g_rand), .g_o0_s0(g_o0_s0), .g_o0_s1(g_o0_s1),
      .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_id(out_id),
      .seed_load(seed_load), .seed_value(seed_value)
   );

   assign gsh = {g_i1_s1, g_i1_s0, g_i0_s1, g_i0_s0};

   // Behavioural HPC2 gadget: one register stage, output shares XOR to a&b.
   always @(posedge clock_0) begin
      g_o0_s0 <= (g_i0_s0 & g_i1_s0) ^ g_rand;
      g_o0_s1 <= (g_i0_s1 & g_i1_s1) ^ (g_i0_s0 & g_i1_s1) ^ (g_i0_s1 & g_i1_s0) ^ g_rand;
   end

   function automatic logic unmask(input logic [3:0] o);
      return (o[0] ^ o[1]) & (o[2] ^ o[3]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock_0);
      #1;
   endtask

   task automatic pulse_reset();
      reset_0 = 1'b0;
      cyc();
      reset_0 = 1'b1;
   endtask

   // Scoreboard: expected {id, a&b} pushed on every grant, popped on every accepted result.
   always @(negedge clock_0) begin
      if (!reset_0) begin
         sb.delete();
      end else begin
         chk("single_grant", {31'd0, req0_ready & req1_ready}, 0);
         if (req0_ready) sb.push_back({1'b0, unmask(req0_ops)});
         if (req1_ready) sb.push_back({1'b1, unmask(req1_ops)});
         if (req0_ready || req1_ready)
            chk("gadget_shares", {28'd0, gsh}, {28'd0, req1_ready ? req1_ops : req0_ops});
         else
            chk("idle_shares_zero", {28'd0, gsh}, 0);
         if (out_valid && out_ready) begin
            nvec++;
            assert (sb.size() > 0) else begin
               nerr++;
               $error("FAIL unexpected_result observed=%0h expected=none", {out_id, out_s});
            end
            if (sb.size() > 0) begin
               exp_r = sb.pop_front();
               chk("result_id_value", {30'd0, out_id, out_s[1] ^ out_s[0]}, {30'd0, exp_r});
            end
         end
      end
   end

   initial begin
      logic [7:0] rseq;
      int         acc;
      logic       g0, g1;
      // g_rand per issue after reset: bit0 of ACE1,5670,AB38,559C,2ACE,1567,8AB3,4559
      rseq = 8'hE1;

      // Reset state, with a request pending to show it is not granted.
      reset_0 = 1'b0; req0_valid = 1'b1; req0_ops = 4'hF;
      req1_valid = 1'b0; req1_ops = 4'h0; out_ready = 1'b1;
      seed_load = 1'b0; seed_value = 16'h0;
      repeat (2) @(posedge clock_0);
      @(negedge clock_0);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_out_s", {30'd0, out_s}, 0);
      chk("rst_out_id", {31'd0, out_id}, 0);
      chk("rst_req0_ready", {31'd0, req0_ready}, 0);
      chk("rst_gshares", {28'd0, gsh}, 0);
      chk("rst_g_rand", {31'd0, g_rand}, 1);

      // Single op from req0: a=1 (s0=1,s1=0), b=1 (s0=0,s1=1).
      req0_valid = 1'b0; req0_ops = 4'h0;
      cyc(); reset_0 = 1'b1;
      cyc(); req0_valid = 1'b1; req0_ops = 4'b1001;
      @(negedge clock_0);
      chk("t1_ready", {31'd0, req0_ready}, 1);
      chk("t1_g_rand", {31'd0, g_rand}, 1);
      cyc(); req0_valid = 1'b0;
      @(negedge clock_0);
      chk("t1_no_valid_t1", {31'd0, out_valid}, 0);
      cyc();
      @(negedge clock_0);
      chk("t1_valid_t2", {31'd0, out_valid}, 1);
      chk("t1_unmasked", {31'd0, out_s[1] ^ out_s[0]}, 1);
      chk("t1_id", {31'd0, out_id}, 0);
      cyc();

      // Both requesters streaming: grants alternate starting at req0, one result per cycle.
      pulse_reset();
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_ops = 4'($urandom); req1_ops = 4'($urandom);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock_0);
         g0 = req0_ready; g1 = req1_ready;
         chk("rr_grant0", {31'd0, g0}, {31'd0, (i % 2) == 0});
         chk("rr_grant1", {31'd0, g1}, {31'd0, (i % 2) == 1});
         if (i >= 2) chk("rr_throughput", {31'd0, out_valid}, 1);
         cyc();
         if (g0) req0_ops = 4'($urandom);
         if (g1) req1_ops = 4'($urandom);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (4) cyc();
      chk("rr_drained", sb.size(), 0);

      // Downstream stalled: exactly FIFO_DEPTH accepts, then no credit.
      out_ready = 1'b0; req0_valid = 1'b1; req0_ops = 4'($urandom); acc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock_0);
         g0 = req0_ready;
         if (g0) acc++;
         cyc();
         if (g0) req0_ops = 4'($urandom);
      end
      chk("full_accepts", acc, 4);
      @(negedge clock_0);
      chk("full_ready_low", {31'd0, req0_ready}, 0);
      chk("full_head_valid", {31'd0, out_valid}, 1);
      // Release: no accept in the first cycle (credit lags the pop), then one per cycle.
      cyc(); out_ready = 1'b1; acc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock_0);
         g0 = req0_ready;
         if (g0) acc++;
         cyc();
         if (g0) req0_ops = 4'($urandom);
      end
      chk("release_accepts", acc, 9);
      req0_valid = 1'b0;
      repeat (6) cyc();
      chk("release_drained", sb.size(), 0);
      chk("release_out_valid", {31'd0, out_valid}, 0);

      // Randomness: 3 issues, 2 idle cycles (LFSR holds), 5 more issues.
      pulse_reset();
      req0_valid = 1'b1; req0_ops = 4'($urandom);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock_0);
         chk("rand_seq_a", {31'd0, g_rand}, {31'd0, rseq[i]});
         chk("rand_ready_a", {31'd0, req0_ready}, 1);
         cyc(); req0_ops = 4'($urandom);
      end
      req0_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock_0);
         chk("idle_gshares", {28'd0, gsh}, 0);
         chk("idle_rand", {31'd0, g_rand}, 0);
         cyc();
      end
      req0_valid = 1'b1;
      for (int i = 3; i < 8; i++) begin
         @(negedge clock_0);
         chk("rand_seq_b", {31'd0, g_rand}, {31'd0, rseq[i]});
         cyc(); req0_ops = 4'($urandom);
      end

      // Reseed with zero during an issue (LFSR now 22AC): issue uses old bit, then SEED.
      seed_load = 1'b1; seed_value = 16'h0000;
      @(negedge clock_0);
      chk("seed0_issue_old", {31'd0, g_rand}, 0);
      chk("seed0_ready", {31'd0, req0_ready}, 1);
      cyc(); seed_load = 1'b0; req0_ops = 4'($urandom);
      @(negedge clock_0);
      chk("seed0_loaded", {31'd0, g_rand}, 1);
      cyc(); req0_ops = 4'($urandom);
      @(negedge clock_0);
      chk("seed0_step", {31'd0, g_rand}, 0);
      cyc(); seed_load = 1'b1; seed_value = 16'h0001; req0_ops = 4'($urandom);
      @(negedge clock_0);
      chk("seed1_issue_old", {31'd0, g_rand}, 0);
      cyc(); seed_load = 1'b0; req0_ops = 4'($urandom);
      @(negedge clock_0);
      chk("seed1_loaded", {31'd0, g_rand}, 1);
      cyc(); req0_ops = 4'($urandom);
      @(negedge clock_0);
      chk("seed1_step", {31'd0, g_rand}, 0);
      cyc(); req0_valid = 1'b0;
      repeat (4) cyc();
      chk("seed_drained", sb.size(), 0);

      // Reset with one op in flight and two FIFO entries.
      out_ready = 1'b0; req0_valid = 1'b1; req0_ops = 4'b0101;
      repeat (3) cyc();
      chk("pre_reset_valid", {31'd0, out_valid}, 1);
      req0_valid = 1'b0;
      #1 reset_0 = 1'b0;
      #1;
      chk("reset_async_valid", {31'd0, out_valid}, 0);
      chk("reset_async_out_s", {30'd0, out_s}, 0);
      cyc(); cyc();
      reset_0 = 1'b1; out_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_ops = 4'b1111; req1_ops = 4'b0110;
      @(negedge clock_0);
      chk("post_reset_grant0", {31'd0, req0_ready}, 1);
      chk("post_reset_grant1", {31'd0, req1_ready}, 0);
      chk("post_reset_valid", {31'd0, out_valid}, 0);
      chk("post_reset_rand", {31'd0, g_rand}, 1);
      cyc();
      @(negedge clock_0);
      chk("post_reset_no_stale", {31'd0, out_valid}, 0);
      repeat (4) cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (5) cyc();
      chk("final_drained", sb.size(), 0);
      chk("final_out_valid", {31'd0, out_valid}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/hpc2_and_scheduler.md
Name: hpc2_and_scheduler

Overview:
- Controller that shares one first-order HPC2 masked AND gadget (2 shares per operand, 1 fresh random bit per operation, 1-cycle latency) between two requesters.
- Arbitrates round-robin, drives gadget input shares and fresh randomness from an internal LFSR, and tags each result with its requester ID.
- Results are buffered in a credit-controlled FIFO, because the gadget pipeline cannot be stalled.
- Sits between masked datapath producers and the gadget instance in masked S-box/AND-tree datapaths.

Parameters:
- LFSR_W, 16, width of the randomness LFSR (fixed taps for 16: x^16+x^14+x^13+x^11+1, Fibonacci, shift toward bit 0).
- SEED, 16'hACE1, LFSR reset value; also loaded when seed_value==0 is presented.
- FIFO_DEPTH, 4, result FIFO entries; must be >=3 to allow one issue per cycle.

Ports:
- clock_0  in  1  single clock, rising edge
- reset_0  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 operation valid
- req0_ready  out  1  requester 0 accepted (grant this cycle)
- req0_ops  in  4  {b_s1,b_s0,a_s1,a_s0} shares for requester 0
- req1_valid  in  1  requester 1 operation valid
- req1_ready  out  1  requester 1 accepted
- req1_ops  in  4  {b_s1,b_s0,a_s1,a_s0} shares for requester 1
- g_i0_s0, g_i0_s1, g_i1_s0, g_i1_s1  out  1 each  gadget operand shares (a=i0, b=i1)
- g_rand  out  1  gadget fresh random bit
- g_o0_s0, g_o0_s1  in  1 each  gadget result shares
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_s  out  2  {s1,s0} result shares
- out_id  out  1  requester ID of head result
- seed_load  in  1  load seed_value into LFSR
- seed_value  in  LFSR_W  new seed

Behaviour:
- Reset (reset_0=0, async): FIFO empty, count=0, inflight=0, last_grant=1, LFSR=SEED. Outputs: out_valid=0, out_s=0, out_id=0, req*_ready=0, g_* shares=0, g_rand=LFSR[0].
- Credit:
  - can_issue = (fifo_count + inflight) < FIFO_DEPTH, computed from registered values only.
  - A pop in the same cycle does not add credit.
- Arbitration (combinational):
  - Only one valid with can_issue: that requester is granted.
  - Both valid: grant !last_grant.
  - No can_issue: no grant, both readies 0.
  - readyN=1 only for the granted requester.
  - last_grant updates only on a grant.
- Issue cycle t:
  - g_i* shares = granted ops; g_rand = LFSR[0].
  - At the edge: inflight<=1, inflight_id<=granted ID, LFSR steps once.
  - No issue: inflight<=0; g_i* shares all driven 0 (never hold stale secret shares); LFSR holds.
- Capture cycle t+1: if inflight, {g_o0_s1,g_o0_s0} and inflight_id are written into the FIFO at the end of t+1. Earliest out_valid is cycle t+2.
- FIFO:
  - Registered head; pop when out_valid&&out_ready.
  - Simultaneous write and pop allowed; count unchanged.
  - Overflow is impossible by credit; a write while full is a design error (assertion).
- Steady-state throughput: 1 op/cycle with out_ready held high and FIFO_DEPTH>=3.
- LFSR:
  - seed_load has priority over stepping. If an issue occurs in the same cycle, the issue uses the current LFSR[0]; the register then loads the seed and does not step.
  - seed_value==0 loads SEED (the all-zero state is forbidden).
- Reset mid-operation: in-flight operation and FIFO contents are discarded. No result is emitted for ops accepted before reset.
- Requesters must hold valid/ops until ready; this block does not check that.

Test Plan:
- Reset, then req0 only: a=1 (s0=1,s1=0), b=1 (s0=0,s1=1).
  - Required: req0_ready=1 at t, g_rand=1 (SEED bit0), out_valid at t+2, out_s0^out_s1=1, out_id=0.
- Both requesters valid continuously, out_ready=1.
  - Required: grants alternate 0,1,0,1 starting with 0; one result/cycle; IDs match grant order; unmasked results equal a&b.
- out_ready=0, req0 streaming.
  - Required: exactly 4 accepts, then req0_ready=0.
  - Raise out_ready: one new accept per pop after the credit delay; no loss or reorder.
- Randomness check: issue 3 ops back-to-back after reset.
  - Required: g_rand sequence equals LFSR bit0 of SEED, step1, step2.
  - On an idle cycle the LFSR does not advance; on idle cycles g_i* shares are 0.
- seed_load with seed_value=0, coinciding with an issue.
  - Required: issue uses the old LFSR[0]; next g_rand = SEED[0].
  - With seed_value=16'h0001: next g_rand=1.
- Assert reset_0 with one op in flight and 2 FIFO entries.
  - Required: out_valid=0 immediately; after release, no stale result; first new grant goes to req0.
